// File: rtl/serial_add_n.sv
// serial_add_n: multi-cycle add/subtract, D bits per clock.
// One D-bit carry-chain slice; carry registered between digits.
module serial_add_n #(
   parameter int W = 16,
   parameter int D = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         mode,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         ci,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] s,
   output logic         ca,
   output logic         ov
);

   localparam int N  = W / D;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t state_q, state_d;

   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  a_q, a_d;
   logic [W-1:0]  b_q, b_d;
   logic [W-1:0]  res_q, res_d;
   logic [W-1:0]  s_q, s_d;
   logic          carry_q, carry_d;
   logic          ca_q, ca_d;
   logic          ov_q, ov_d;

   logic [D:0]    dsum;
   logic          c_msb;
   logic          last;
   logic [W-1:0]  res_shift;

   // One digit through the slice; carry into the digit MSB recovered
   // from the sum bit so the top bit's carry-in is isolated.
   always_comb begin
      dsum      = {1'b0, a_q[D-1:0]}
                + {1'b0, b_q[D-1:0]}
                + (D+1)'(carry_q);
      c_msb     = dsum[D-1] ^ a_q[D-1] ^ b_q[D-1];
      last      = (cnt_q == CW'(N - 1));
      res_shift = (res_q >> D)
                | (W'(dsum[D-1:0]) << (W - D));
   end

   // Next-state and handshake outputs for the IDLE/RUN/DONE sequencer.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      a_d       = a_q;
      b_d       = b_q;
      res_d     = res_q;
      carry_d   = carry_q;
      s_d       = s_q;
      ca_d      = ca_q;
      ov_d      = ov_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               a_d     = a;
               b_d     = mode ? ~b : b;
               carry_d = mode ? 1'b1 : ci;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            a_d     = a_q >> D;
            b_d     = b_q >> D;
            res_d   = res_shift;
            carry_d = dsum[D];
            if (last) begin
               s_d     = res_shift;
               ca_d    = dsum[D];
               ov_d    = c_msb ^ dsum[D];
               cnt_d   = '0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, shift registers and held result; reset aborts any operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         s_q     <= '0;
         ca_q    <= 1'b0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         s_q     <= s_d;
         ca_q    <= ca_d;
         ov_q    <= ov_d;
      end
   end

   assign s  = s_q;
   assign ca = ca_q;
   assign ov = ov_q;

endmodule
